// File: rtl/foc_pkg.sv
// Shared FOC codebook definitions for the crosstalk-avoidance link.
// The encoder and decoder both use this table.
package foc_pkg;

    localparam int FOC_CW_W  = 5;
    localparam int FOC_NIB_W = 4;

    // Ascending list of 5-bit words that contain neither "010" nor "101".
    localparam logic [FOC_CW_W-1:0] FOC_CODEBOOK [0:15] = '{
        5'b00000, 5'b00001, 5'b00011, 5'b00110,
        5'b00111, 5'b01100, 5'b01110, 5'b01111,
        5'b10000, 5'b10001, 5'b10011, 5'b11000,
        5'b11001, 5'b11100, 5'b11110, 5'b11111
    };

    function automatic logic foc_is_valid(input logic [FOC_CW_W-1:0] cw);
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (cw == FOC_CODEBOOK[n]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/foc_dec.sv
// Single-lane FOC decoder: 5-bit codeword to 4-bit nibble plus invalid flag.
// Purely combinational; codewords outside the table decode to nibble 0.
module foc_dec
    import foc_pkg::*;
(
    input  logic [FOC_CW_W-1:0]  cw,
    output logic [FOC_NIB_W-1:0] nib,
    output logic                 invalid
);

    always_comb begin
        nib     = '0;
        invalid = !foc_is_valid(cw);
        for (int n = 0; n < 16; n++) begin
            if (cw == FOC_CODEBOOK[n]) nib = FOC_NIB_W'(n);
        end
    end

endmodule

// File: rtl/foc_dec_top.sv
// Receive-side FOC decoder: LANES codewords per word, two-stage valid pipeline,
// per-lane invalid detection and a saturating erroneous-word counter.
module foc_dec_top
    import foc_pkg::*;
#(
    parameter int LANES = 8,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [FOC_CW_W*LANES-1:0]   data_in,
    input  logic                        err_cnt_clr,
    output logic                        out_valid,
    output logic [FOC_NIB_W*LANES-1:0]  data_out,
    output logic [LANES-1:0]            err_lane,
    output logic                        err_any,
    output logic [CNT_W-1:0]            err_cnt
);

    logic                        vld_p1;
    logic [FOC_CW_W*LANES-1:0]   data_p1;
    logic [FOC_NIB_W*LANES-1:0]  dec_nib;
    logic [LANES-1:0]            dec_err;
    logic                        word_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stage 1: capture the coded word.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) data_p1 <= data_in;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        foc_dec u_dec (
            .cw      (data_p1[FOC_CW_W*g +: FOC_CW_W]),
            .nib     (dec_nib[FOC_NIB_W*g +: FOC_NIB_W]),
            .invalid (dec_err[g])
        );
    end

    assign word_err = vld_p1 & (|dec_err);

    // Stage 2: register decoded nibbles and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            err_lane  <= '0;
            err_any   <= 1'b0;
        end else begin
            out_valid <= vld_p1;
            err_any   <= word_err;
            if (vld_p1) begin
                data_out <= dec_nib;
                err_lane <= dec_err;
            end
        end
    end

    // Clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || err_cnt_clr) begin
            err_cnt <= '0;
        end else if (word_err) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_foc_dec_top.sv
// Self-checking bench for foc_dec_top: directed scenarios plus random traffic
// against an edge-by-edge behavioural model of the decoder link.
module tb_foc_dec_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [39:0] data_in;
    logic        err_cnt_clr;

    logic        out_valid,   out_valid_s;
    logic [31:0] data_out,    data_out_s;
    logic [7:0]  err_lane,    err_lane_s;
    logic        err_any,     err_any_s;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt_s;

    always #5 clk = ~clk;

    foc_dec_top #(.LANES(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .err_cnt_clr(err_cnt_clr), .out_valid(out_valid), .data_out(data_out),
        .err_lane(err_lane), .err_any(err_any), .err_cnt(err_cnt)
    );

    foc_dec_top #(.LANES(8), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .err_cnt_clr(err_cnt_clr), .out_valid(out_valid_s), .data_out(data_out_s),
        .err_lane(err_lane_s), .err_any(err_any_s), .err_cnt(err_cnt_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] cb [16];

    // Model state: what the outputs must be after the most recent edge.
    bit          exp_vld;
    logic [31:0] exp_data;
    logic [7:0]  exp_lane;
    bit          exp_any;
    int          exp_cnt, exp_cnt4;
    bit          prev_vld, prev_rst;
    logic [39:0] prev_data;

    function automatic bit has_bad(input logic [4:0] v);
        bit b;
        b = 0;
        for (int i = 0; i < 3; i++) begin
            if (((v >> i) & 5'd7) == 5'd2 || ((v >> i) & 5'd7) == 5'd5) b = 1;
        end
        return b;
    endfunction

    function automatic logic [4:0] rand_bad();
        logic [4:0] v;
        v = 5'($urandom_range(31));
        while (!has_bad(v)) v = 5'($urandom_range(31));
        return v;
    endfunction

    function automatic logic [39:0] rand_word(input int pbad);
        logic [39:0] w;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(99) < pbad) w[5*i +: 5] = rand_bad();
            else                           w[5*i +: 5] = cb[$urandom_range(15)];
        end
        return w;
    endfunction

    // One clock edge: drive inputs, let the edge pass, advance the model.
    task automatic cycle(input bit r, input bit v, input logic [39:0] d, input bit c);
        int idx;
        rst = r;
        in_valid = v;
        data_in = v ? d : {$urandom, 8'($urandom)};
        err_cnt_clr = c;
        @(posedge clk);
        #1;
        if (r) begin
            exp_vld = 0; exp_data = '0; exp_lane = '0; exp_any = 0;
            exp_cnt = 0; exp_cnt4 = 0;
        end else begin
            exp_vld = prev_vld && !prev_rst;
            if (exp_vld) begin
                for (int i = 0; i < 8; i++) begin
                    idx = -1;
                    for (int n = 0; n < 16; n++) if (cb[n] == prev_data[5*i +: 5]) idx = n;
                    exp_lane[i] = (idx < 0);
                    exp_data[4*i +: 4] = (idx < 0) ? 4'd0 : 4'(idx);
                end
            end
            exp_any = exp_vld && (exp_lane != 0);
            if (c) begin
                exp_cnt = 0; exp_cnt4 = 0;
            end else if (exp_any) begin
                if (exp_cnt  < 65535) exp_cnt++;
                if (exp_cnt4 < 15)    exp_cnt4++;
            end
        end
        prev_vld = v; prev_rst = r; prev_data = d;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, '0, 0);
            n_checks++;
            if ({out_valid, data_out, err_lane, err_any, err_cnt} !== 58'd0) begin
                n_fail++;
                $display("FAIL reset_state: got v=%0b d=%h l=%h a=%0b cnt=%0d want all zero",
                         out_valid, data_out, err_lane, err_any, err_cnt);
            end
        end
    endtask

    task automatic test_single();
        logic [39:0] w;
        int pulses;
        for (int i = 0; i < 8; i++) w[5*i +: 5] = cb[i+1];
        pulses = 0;
        cycle(0, 1, w, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, '0, 0);
            if (out_valid) pulses++;
            n_checks++;
            if ({out_valid, data_out, err_lane, err_any} !== {exp_vld, exp_data, exp_lane, exp_any}) begin
                n_fail++;
                $display("FAIL single_model: got v=%0b d=%h l=%h a=%0b want v=%0b d=%h l=%h a=%0b",
                         out_valid, data_out, err_lane, err_any, exp_vld, exp_data, exp_lane, exp_any);
            end
            if (k == 0) begin
                n_checks++;
                if ({out_valid, data_out, err_lane} !== {1'b1, 32'h87654321, 8'h00}) begin
                    n_fail++;
                    $display("FAIL single_latency: got v=%0b d=%h l=%h want v=1 d=87654321 l=00",
                             out_valid, data_out, err_lane);
                end
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL single_pulse: got %0d valid cycles want 1", pulses);
        end
    endtask

    task automatic test_stream();
        logic [3:0] nb;
        int hits;
        hits = 0;
        for (int j = 0; j < 19; j++) begin
            if (j < 16) cycle(0, 1, {8{cb[j]}}, 0);
            else        cycle(0, 0, '0, 0);
            if (j >= 1 && j <= 16) begin
                nb = 4'(j - 1);
                n_checks++;
                if ({out_valid, data_out} !== {1'b1, {8{nb}}}) begin
                    n_fail++;
                    $display("FAIL stream_word%0d: got v=%0b d=%h want v=1 d=%h",
                             j - 1, out_valid, data_out, {8{nb}});
                end else hits++;
            end else begin
                n_checks++;
                if (out_valid !== exp_vld) begin
                    n_fail++;
                    $display("FAIL stream_edge: got v=%0b want v=%0b at step %0d", out_valid, exp_vld, j);
                end
            end
        end
        n_checks++;
        if (hits != 16) begin
            n_fail++;
            $display("FAIL stream_count: got %0d good words want 16", hits);
        end
    endtask

    task automatic test_error();
        logic [39:0] w1, w3;
        for (int i = 0; i < 8; i++) w1[5*i +: 5] = cb[i];
        w1[19:15] = 5'b01010;
        w3 = w1;
        w3[19:15] = cb[3];
        w3[4:0]   = 5'b10101;
        w3[24:20] = 5'b01010;
        w3[39:35] = 5'b00010;
        cycle(0, 0, '0, 1);
        cycle(0, 1, w1, 0);
        cycle(0, 1, w3, 0);
        n_checks++;
        if ({out_valid, data_out, err_lane, err_any, err_cnt} !== {1'b1, 32'h76540210, 8'h08, 1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL err_lane3: got v=%0b d=%h l=%h a=%0b cnt=%0d want v=1 d=76540210 l=08 a=1 cnt=1",
                     out_valid, data_out, err_lane, err_any, err_cnt);
        end
        cycle(0, 0, '0, 0);
        n_checks++;
        if ({err_lane, err_any, err_cnt} !== {8'h91, 1'b1, 16'd2}) begin
            n_fail++;
            $display("FAIL err_three: got l=%h a=%0b cnt=%0d want l=91 a=1 cnt=2", err_lane, err_any, err_cnt);
        end
        cycle(0, 0, '0, 0);
        n_checks++;
        if ({out_valid, err_any, err_lane, err_cnt} !== {1'b0, 1'b0, 8'h91, 16'd2}) begin
            n_fail++;
            $display("FAIL err_idle_hold: got v=%0b a=%0b l=%h cnt=%0d want v=0 a=0 l=91 cnt=2",
                     out_valid, err_any, err_lane, err_cnt);
        end
    endtask

    task automatic test_saturation();
        cycle(0, 0, '0, 1);
        for (int k = 0; k < 20; k++) cycle(0, 1, rand_word(100), 0);
        cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 0);
        n_checks++;
        if ({err_cnt_s, err_cnt} !== {4'd15, 16'd20}) begin
            n_fail++;
            $display("FAIL sat_stick: got cnt4=%0d cnt16=%0d want cnt4=15 cnt16=20", err_cnt_s, err_cnt);
        end
        cycle(0, 1, rand_word(100), 0);
        cycle(0, 0, '0, 1);
        n_checks++;
        if ({err_any, err_cnt_s, err_cnt} !== {1'b1, 4'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL clr_wins: got a=%0b cnt4=%0d cnt16=%0d want a=1 cnt4=0 cnt16=0",
                     err_any, err_cnt_s, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        cycle(0, 1, {8{cb[9]}}, 0);
        cycle(1, 1, {8{cb[10]}}, 0);
        if (out_valid) seen++;
        cycle(0, 1, {8{cb[5]}}, 0);
        if (out_valid) seen++;
        cycle(0, 0, '0, 0);
        n_checks++;
        if ({out_valid, data_out} !== {1'b1, 32'h55555555}) begin
            n_fail++;
            $display("FAIL rstmid_new: got v=%0b d=%h want v=1 d=55555555", out_valid, data_out);
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rstmid_flush: got %0d stale valid cycles want 0", seen);
        end
    endtask

    task automatic test_random();
        bit r, v, c;
        for (int k = 0; k < 300; k++) begin
            r = ($urandom_range(99) < 3);
            v = ($urandom_range(99) < 70);
            c = ($urandom_range(99) < 5);
            cycle(r, v, rand_word(15), c);
            n_checks++;
            if ({out_valid, data_out, err_lane, err_any} !== {exp_vld, exp_data, exp_lane, exp_any}) begin
                n_fail++;
                $display("FAIL random_out: step %0d got v=%0b d=%h l=%h a=%0b want v=%0b d=%h l=%h a=%0b",
                         k, out_valid, data_out, err_lane, err_any, exp_vld, exp_data, exp_lane, exp_any);
            end
            n_checks++;
            if (err_cnt !== 16'(exp_cnt) || err_cnt_s !== 4'(exp_cnt4)) begin
                n_fail++;
                $display("FAIL random_cnt: step %0d got cnt16=%0d cnt4=%0d want cnt16=%0d cnt4=%0d",
                         k, err_cnt, err_cnt_s, exp_cnt, exp_cnt4);
            end
        end
    endtask

    initial begin
        int n;
        logic [4:0] v;
        n = 0;
        for (int x = 0; x < 32; x++) begin
            v = 5'(x);
            if (!has_bad(v)) begin
                cb[n] = v;
                n++;
            end
        end
        rst = 1'b1; in_valid = 1'b0; data_in = '0; err_cnt_clr = 1'b0;
        prev_vld = 0; prev_rst = 1; prev_data = '0;
        exp_vld = 0; exp_data = '0; exp_lane = '0; exp_any = 0; exp_cnt = 0; exp_cnt4 = 0;

        test_reset();
        test_single();
        test_stream();
        test_error();
        test_saturation();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
